// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NRD      = 2;
  localparam int DEF_ZERO_REG = 31;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register/range masking and write-through bypass.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             busy_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic [WIDTH-1:0] mem_data_i,
  input  logic             wr0_en_i,
  input  logic [AW-1:0]    wr0_addr_i,
  input  logic [WIDTH-1:0] wr0_data_i,
  input  logic             wr1_en_i,
  input  logic [AW-1:0]    wr1_addr_i,
  input  logic [WIDTH-1:0] wr1_data_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic in_range;

  // A power-of-two depth leaves no unmapped address codes to filter out.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (32'(raddr_i) < 32'(DEPTH));
  end

  // NOTE: every path assigns rdata_o, starting from a default, so no latch is inferred.
  always_comb begin
    rdata_o = mem_data_i;
    if (busy_i || !in_range || (raddr_i == AW'(ZERO_REG))) begin
      rdata_o = '0;
    end else if (wr1_en_i && (wr1_addr_i == raddr_i)) begin
      rdata_o = wr1_data_i;
    end else if (wr0_en_i && (wr0_addr_i == raddr_i)) begin
      rdata_o = wr0_data_i;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with a hardwired-zero entry and a
// sequential clear engine that runs after reset and on clr_req.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we0,
  input  logic [AW-1:0]             waddr0,
  input  logic [WIDTH-1:0]          wdata0,
  input  logic                      we1,
  input  logic [AW-1:0]             waddr1,
  input  logic [WIDTH-1:0]          wdata1,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][WIDTH-1:0] rdata,
  input  logic                      clr_req,
  output logic                      busy
);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w0_in_range, w1_in_range;
  logic w0_eff, w1_eff;

  if (DEPTH == (1 << AW)) begin : g_full_range
    assign w0_in_range = 1'b1;
    assign w1_in_range = 1'b1;
  end else begin : g_part_range
    assign w0_in_range = (32'(waddr0) < 32'(DEPTH));
    assign w1_in_range = (32'(waddr1) < 32'(DEPTH));
  end

  assign busy   = (state_q == CLEAR);
  assign w0_eff = we0 && !busy && w0_in_range && (waddr0 != AW'(ZERO_REG));
  assign w1_eff = we1 && !busy && w1_in_range && (waddr1 != AW'(ZERO_REG));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the array has no reset term; it stays a plain RAM and the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (w0_eff) mem_q[waddr0] <= wdata0;
      // Port 1 is assigned last so it wins an address collision.
      if (w1_eff) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .AW      (AW)
    ) u_rdport (
      .busy_i    (busy),
      .raddr_i   (raddr[k]),
      .mem_data_i(mem_q[raddr[k]]),
      .wr0_en_i  (w0_eff),
      .wr0_addr_i(waddr0),
      .wr0_data_i(wdata0),
      .wr1_en_i  (w1_eff),
      .wr1_addr_i(waddr1),
      .wr1_data_i(wdata1),
      .rdata_o   (rdata[k])
    );
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter DEPTH, default 32, number of registers; AW = clog2(DEPTH).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter ZERO_REG, default 31, index of the hardwired-zero register.
REQ-005 The clock port SHALL be: clk  input  1  rising-edge clock.
REQ-006 The reset port SHALL be: rst_n  input  1  asynchronous, active-low reset.
REQ-007 The port we0 SHALL be: we0  input  1  write enable, port 0.
REQ-008 The port waddr0 SHALL be: waddr0  input  AW  write address, port 0.
REQ-009 The port wdata0 SHALL be: wdata0  input  WIDTH  write data, port 0.
REQ-010 Write port 1 SHALL be: we1 / waddr1 / wdata1  input  1 / AW / WIDTH  same meanings as port 0.
REQ-011 The port raddr SHALL be: raddr  input  NRD x AW  read addresses.
REQ-012 The port rdata SHALL be: rdata  output  NRD x WIDTH  read data.
REQ-013 The port clr_req SHALL be: clr_req  input  1  one-cycle request to clear all registers.
REQ-014 The port busy SHALL be: busy  output  1  clear sequence in progress.

Function
REQ-015 FSM states SHALL be CLEAR and IDLE, with a clear counter cnt of width AW.
REQ-016 In CLEAR, each cycle SHALL write 0 to entry cnt and increment cnt; after entry DEPTH-1 is cleared, the next state SHALL be IDLE.
REQ-017 A full clear SHALL take exactly DEPTH cycles after reset deassertion or after clr_req is sampled; busy=1 throughout the clear and busy=0 in IDLE.
REQ-018 clr_req sampled high in IDLE SHALL enter CLEAR with cnt=0 on the next cycle; clr_req in CLEAR SHALL be ignored.
REQ-019 In CLEAR, we0/we1 SHALL be ignored and all rdata SHALL read 0.
REQ-020 In IDLE, weN=1 SHALL write wdataN to waddrN on the rising clk edge.
REQ-021 If we0 and we1 are both 1 with waddr0==waddr1, port 1 SHALL win.
REQ-022 Writes to ZERO_REG or to addresses >= DEPTH SHALL be discarded.
REQ-023 Reads SHALL be combinational, with zero latency.
REQ-024 Reads of ZERO_REG or of addresses >= DEPTH SHALL return 0.
REQ-025 Write-through bypass: if an effective write in the same cycle targets raddr[k], rdata[k] SHALL return that write data, with port 1 priority over port 0.
REQ-026 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-027 rst_n low SHALL immediately force state=CLEAR, cnt=0 and busy=1; register contents are not reset directly.
REQ-028 On rst_n release, the clear SHALL run per REQ-016/017.
REQ-029 Reset asserted mid-clear SHALL restart the clear from cnt=0.
REQ-030 While rst_n is low, rdata SHALL read 0.

Structure
REQ-031 Package regfile_pkg SHALL hold the state enum (CLEAR, IDLE) and the default constants (WIDTH, DEPTH, NRD, ZERO_REG).
REQ-032 The read port SHALL be a sub-module regfile_rdport, instantiated NRD times; it contains the zero/range check and the bypass mux.

Verification
REQ-033 Reset scenario: release rst_n, count cycles -> busy=1 for exactly 32 cycles, then 0; every raddr reads 0.
REQ-034 Write scenario: we0, waddr0=5, wdata0=DEADBEEF; next cycle raddr[0]=5 -> rdata[0]=DEADBEEF; same-cycle read of 5 -> DEADBEEF via bypass.
REQ-035 Collision scenario: we0/we1 both to 7, data 11111111/22222222 -> reg 7 = 22222222; bypass also returns 22222222.
REQ-036 Zero-register scenario: we1 to 31 with FFFFFFFF -> raddr=31 reads 0 in the same cycle and afterwards.
REQ-037 Clear scenario: load regs 1..30; pulse clr_req -> busy=1 for 32 cycles, writes during that window are ignored, and all regs read 0 afterwards.
REQ-038 Mid-clear reset scenario: assert rst_n low at cnt=10 -> after release, busy=1 for a full 32 cycles.
